// File: rtl/hidden_layer_pkg.sv
// Shared constants, state encoding and saturation helper for the hidden layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: HID_N_NEURONS, HID_N_IN, HID_SHIFT, ACT_W, ACC_W(), hid_state_t, sat8().
package nn_pkg;

  localparam int HID_N_NEURONS = 10;
  localparam int HID_N_IN      = 16;
  localparam int HID_SHIFT     = 4;
  localparam int ACT_W         = 8;

  // 16-bit products, N_IN of them, plus one bit of headroom for the bias.
  function automatic int ACC_W(input int n_in);
    return 16 + $clog2(n_in) + 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    ACT,
    DONE
  } hid_state_t;

  // Signed saturation of a wide value into [-128, 127].
  function automatic logic [7:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127) begin
      return 8'h7f;
    end else if (v < -32'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/hidden_layer_if.sv
// Beat stream, run control and result bus of the hidden layer.
// Latency: n/a (wires only).
// Backpressure: in_ready qualifies in_valid; a beat moves when both are high.
// master drives start/in_valid/x/w/b; slave (the engine) drives in_ready/outreg/busy/done.
interface hidden_layer_if #(
  parameter int N_NEURONS = nn_pkg::HID_N_NEURONS
);
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [7:0]         x;
  logic signed [7:0]         w;
  logic signed [7:0]         b;
  logic [8*N_NEURONS-1:0]    outreg;
  logic                      busy;
  logic                      done;

  modport master (
    output start, in_valid, x, w, b,
    input  in_ready, outreg, busy, done
  );

  modport slave (
    input  start, in_valid, x, w, b,
    output in_ready, outreg, busy, done
  );
endinterface

// File: rtl/hidden_layer_mac.sv
// Per-neuron accumulator with bias load, MAC, hold and clear, plus scaled activation.
// Latency: acc updates on the clock edge after a control pulse; act is combinational from acc.
// Backpressure: none; the caller pulses load_bias/mac_en only on accepted beats.
// Ports: clk, rst, clear, load_bias, mac_en, x, w, b in; act (8-bit result) out.
// Build option: HIDDEN_RELU_EN selects ReLU-clamp to [0,127]; otherwise signed saturation.
module hidden_mac
  import nn_pkg::*;
#(
  parameter int N_IN  = HID_N_IN,
  parameter int SHIFT = HID_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_bias,
  input  logic              mac_en,
  input  logic signed [7:0] x,
  input  logic signed [7:0] w,
  input  logic signed [7:0] b,
  output logic [ACT_W-1:0]  act
);

  localparam int AW = ACC_W(N_IN);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] r;
  logic signed [15:0]   prod;
  logic signed [31:0]   r32;

  assign prod = x * w;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (load_bias) begin
      // Bias lives in the same fixed-point scale as the products.
      acc <= $signed({{(AW-8){b[7]}}, b}) <<< SHIFT;
    end else if (mac_en) begin
      acc <= acc + $signed({{(AW-16){prod[15]}}, prod});
    end
  end

  assign r   = acc >>> SHIFT;
  assign r32 = 32'(r);

`ifdef HIDDEN_RELU_EN
  // Negative values clamp to zero first, so sat8 only ever trims the top.
  assign act = sat8((r32 < 0) ? 32'sd0 : r32);
`else
  assign act = sat8(r32);
`endif

endmodule

// File: rtl/hidden_layer.sv
// Sequential hidden-layer engine: one bias beat + N_IN MAC beats per neuron, N_NEURONS neurons.
// Latency: N_IN+2 cycles per neuron with in_valid held high; done 1+N_NEURONS*(N_IN+2) cycles after start.
// Backpressure: in_ready high only in BIAS/MAC while start is high; in_valid gaps stall in place.
// Ports: clk, rst (sync, active high); bus (hidden_layer_if.slave): start, in_valid/in_ready,
// x/w/b beats, outreg (neuron k at [8k+7:8k]), busy, done.
// Build option: HIDDEN_RELU_EN (activation select, see hidden_mac).
module hidden_layer
  import nn_pkg::*;
#(
  parameter int N_NEURONS = HID_N_NEURONS,
  parameter int N_IN      = HID_N_IN,
  parameter int SHIFT     = HID_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  hidden_layer_if.slave  bus
);

  localparam int NW = $clog2(N_NEURONS);
  localparam int BW = $clog2(N_IN);

  hid_state_t                   state;
  logic [NW-1:0]                nidx;
  logic [BW-1:0]                bidx;
  logic [ACT_W*N_NEURONS-1:0]   outreg_q;
  logic                         busy_q;
  logic                         done_q;
  logic [ACT_W-1:0]             act;
  logic                         xfer;

  // Gating on start makes an abort cycle refuse the beat on the bus.
  assign bus.in_ready = bus.start && ((state == BIAS) || (state == MAC));
  assign xfer         = bus.in_valid && bus.in_ready;
  assign bus.outreg   = outreg_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  hidden_mac #(
    .N_IN  (N_IN),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state == IDLE) && bus.start),
    .load_bias (xfer && (state == BIAS)),
    .mac_en    (xfer && (state == MAC)),
    .x         (bus.x),
    .w         (bus.w),
    .b         (bus.b),
    .act       (act)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      nidx     <= '0;
      bidx     <= '0;
      outreg_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= BIAS;
            nidx   <= '0;
            bidx   <= '0;
            busy_q <= 1'b1;
          end
        end
        BIAS: begin
          if (!bus.start) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.in_valid) begin
            bidx  <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (!bus.start) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.in_valid) begin
            if (bidx == BW'(N_IN - 1)) begin
              state <= ACT;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
        ACT: begin
          if (!bus.start) begin
            // Aborting here drops the neuron in flight; earlier slots stay.
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            outreg_q[int'(nidx)*ACT_W +: ACT_W] <= act;
            if (nidx == NW'(N_NEURONS - 1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              nidx  <= nidx + 1'b1;
              state <= BIAS;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hidden_layer.md
# hidden_layer

Hidden-layer engine of the neural-navigator datapath: evaluates `N_NEURONS` neurons one after another. Each neuron takes one bias beat and `N_IN` (input, weight) beats, accumulates them, applies activation and saturation, and writes an 8-bit result into a packed output register. That register is the `outreg` bus consumed by the output layer. Raising `done` tells the output-layer controller that `outreg` is complete and stable.

## Interface
- `N_NEURONS`, 10: neurons evaluated per run; `outreg` width is 8·N_NEURONS.
- `N_IN`, 16: MAC beats per neuron.
- `SHIFT`, 4: fixed-point scale; bias is pre-shifted left and the final sum is shifted right by `SHIFT`.

Ports:
- `clk`  in  1: sole clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level request; run proceeds while high.
- `in_valid`  in  1: `x`/`w`/`b` beat valid.
- `in_ready`  out  1: block accepts a beat this cycle.
- `x`  in  8 signed: input activation (MAC beats).
- `w`  in  8 signed: weight (MAC beats).
- `b`  in  8 signed: bias (bias beat only).
- `outreg`  out  8·N_NEURONS: neuron k result at bits [8k+7:8k].
- `busy`  out  1: state ≠ IDLE and ≠ DONE.
- `done`  out  1: run complete; `outreg` valid.

## Operation
- The accumulator is signed, `ACC_W = 16 + clog2(N_IN) + 1` bits (21 at defaults).
- A beat transfers on a cycle where `in_valid && in_ready` is true.
- States:
  - IDLE: `in_ready`=0. If `start`=1, go to BIAS, clear neuron index `nidx` and beat index `bidx`.
  - BIAS: `in_ready`=1. On transfer, load `acc <= sext(b) <<< SHIFT`, set `bidx`=0, go to MAC. `x`/`w` are ignored.
  - MAC: `in_ready`=1. On transfer, `acc <= acc + x*w` (signed 16-bit product, sign-extended). On the beat where `bidx == N_IN-1`, go to ACT; otherwise increment `bidx`.
  - ACT: `in_ready`=0, one cycle.
    - Compute `r = acc >>> SHIFT`, then apply activation and saturation (see Configuration).
    - Write `r` to slot `nidx` of `outreg`.
    - If `nidx == N_NEURONS-1`, go to DONE; otherwise increment `nidx` and go to BIAS.
  - DONE: `done`=1, `in_ready`=0. `outreg` is frozen. When `start` falls, go to IDLE.
- Abort: `start`=0 in BIAS, MAC or ACT returns to IDLE next cycle.
  - A beat presented in that cycle is not transferred (`in_ready` already reflects `start`).
  - Slots written so far are kept; `done` stays 0.
- A new run, `start` rising from IDLE, does not clear `outreg`; each slot is overwritten when its neuron completes.
- `in_valid` low in BIAS/MAC stalls with no state change; gaps of any length are allowed.

## Timing
- Reset values: state IDLE, `outreg`=0, `acc`=0, `nidx`=`bidx`=0, `in_ready`=0, `busy`=0, `done`=0.
- `rst` has priority over every other input, including in mid-run.
- `in_ready` is combinational from state and `start`.
- `done` and `outreg` are registered.
- With `in_valid` held high, one neuron takes N_IN+2 cycles.
- `done` rises 1 + N_NEURONS·(N_IN+2) cycles after the first rising edge with `start`=1: 181 cycles at defaults.
- The slot `nidx` write is visible on `outreg` the cycle after ACT.
- `done` rises in the same cycle that the last slot becomes visible.
- `done` is held while `start`=1 and falls the cycle after `start` falls.

## Configuration
- Macro `HIDDEN_RELU_EN`.
- Defined (ReLU): r<0 gives 0; r>127 gives 127; otherwise r.
- Undefined (linear): signed saturation of r to [-128,127].
- Width and latency are identical in both builds.

## Structure
- Package `nn_pkg` holds:
  - `HID_N_NEURONS`, `HID_N_IN`, `HID_SHIFT`, `ACT_W`=8;
  - the `ACC_W` function;
  - state enum `hid_state_t` {IDLE, BIAS, MAC, ACT, DONE};
  - a shared `sat8` saturation function.
- Sub-module `hidden_mac`: the accumulator register with load-bias, MAC, hold and clear controls, plus the shift/activation/saturation output. The FSM and `outreg` packing stay in `hidden_layer`.

## Test plan
- Unity: all beats x=1, w=1, b=0, `in_valid` always high → every slot 0x01; `outreg`=0x01 repeated 10 times; `done` exactly at cycle 181.
- Positive saturation: x=127, w=127, b=127 → acc=260096, r=16256 → every slot 0x7F.
- Negative: x=1, w=-1, b=0 → r=-1 → slot 0x00 with `HIDDEN_RELU_EN`, 0xFF without. Also b=-128, w=0 → 0x00 with ReLU, 0x80 without.
- Backpressure: random `in_valid` gaps (0–5 cycles) with per-neuron distinct data (neuron k: b=k, x=1, w=1 → r=k+1) → slot k = k+1. `in_ready` never high in IDLE/ACT/DONE.
- Abort and reset:
  - Drop `start` mid-MAC of neuron 3 → IDLE next cycle, slots 0–2 retained, `done`=0.
  - Assert `rst` mid-run → all outputs 0 the next cycle.
  - Restart → full correct result.
- Done handshake: hold `start` high for 20 cycles after `done` → `done` and `outreg` stable. Drop `start` → `done`=0 next cycle; re-raise → new run begins in BIAS.
